// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake and serial framing signals between the serializer and its neighbours.
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_valid, in_data, shift_en,
    input  in_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_valid, in_data, shift_en,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );

endinterface

// File: rtl/piso_hold_reg.sv
// One-entry holding register with a full flag; load and clear never coincide
// because load requires the entry to be empty and clear requires it to be full.
module piso_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      full <= 1'b0;
    end else begin
      if (clear) full <= 1'b0;
      if (load) begin
        q    <= data;
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: one-word hold buffer feeding a shift register,
// reloaded on the last bit so back-to-back words stream without a gap.
//
//   state | meaning
//   IDLE  | no word on the serial output; load from hold as soon as it is full
//   SHIFT | ser_out carries bit cnt of the current word
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  piso_serializer_if.slave bus
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_adv;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic             hold_load;
  logic             hold_clear;

  // in_ready depends only on the registered full flag
  assign hold_load = bus.in_valid && !hold_full;

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .data  (bus.in_data),
    .clear (hold_clear),
    .q     (hold_q),
    .full  (hold_full)
  );

  assign shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    hold_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full) begin
          shreg_d    = hold_q;
          cnt_d      = '0;
          hold_clear = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q != CNT_LAST) begin
            shreg_d = shreg_adv;
            cnt_d   = cnt_q + CW'(1);
          end else if (hold_full) begin
            shreg_d    = hold_q;
            cnt_d      = '0;
            hold_clear = 1'b1;
          end else begin
            // leave an all-zero register behind so the idle line reads 0
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = !hold_full;
  assign bus.ser_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign bus.busy      = (state_q == SHIFT) || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an MSB-first and an LSB-first serializer with the same stimulus and
// checks both against a word/bit-index reference model every cycle.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         shift_en = 1'b0;

  int ncmp = 0;
  int nfail = 0;

  piso_serializer_if #(.WIDTH(W)) if_m ();
  piso_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.in_valid = in_valid;
  assign if_m.in_data  = in_data;
  assign if_m.shift_en = shift_en;
  assign if_l.in_valid = in_valid;
  assign if_l.in_data  = in_data;
  assign if_l.shift_en = shift_en;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l));

  always #5 clk = ~clk;

  // reference model: current word + bit index, plus one pending word
  logic [W-1:0] m_cur, m_hold;
  int           m_idx;
  bit           m_active, m_hold_full;
  bit           str_m[$];
  bit           str_l[$];

  task automatic model_reset();
    m_cur = '0; m_hold = '0; m_idx = 0; m_active = 0; m_hold_full = 0;
  endtask

  function automatic logic exp_bit(input bit msb);
    return msb ? m_cur[W-1-m_idx] : m_cur[m_idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".m.ready"}, 32'(if_m.in_ready),  32'(!m_hold_full));
    chk({tag, ".m.busy"},  32'(if_m.busy),      32'(m_active || m_hold_full));
    chk({tag, ".m.valid"}, 32'(if_m.ser_valid), 32'(m_active));
    chk({tag, ".m.last"},  32'(if_m.ser_last),  32'(m_active && m_idx == W-1));
    chk({tag, ".l.ready"}, 32'(if_l.in_ready),  32'(!m_hold_full));
    chk({tag, ".l.busy"},  32'(if_l.busy),      32'(m_active || m_hold_full));
    chk({tag, ".l.valid"}, 32'(if_l.ser_valid), 32'(m_active));
    chk({tag, ".l.last"},  32'(if_l.ser_last),  32'(m_active && m_idx == W-1));
    if (m_active) begin
      chk({tag, ".m.out"}, 32'(if_m.ser_out), 32'(exp_bit(1'b1)));
      chk({tag, ".l.out"}, 32'(if_l.ser_out), 32'(exp_bit(1'b0)));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_all(tag);
    chk({tag, ".m.out0"}, 32'(if_m.ser_out), 32'd0);
    chk({tag, ".l.out0"}, 32'(if_l.ser_out), 32'd0);
  endtask

  // called at a falling edge with inputs already set for the next rising edge
  task automatic cycle(input string tag);
    bit acc;
    if (!rst && if_m.ser_valid && shift_en) str_m.push_back(if_m.ser_out);
    if (!rst && if_l.ser_valid && shift_en) str_l.push_back(if_l.ser_out);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      acc = in_valid && !m_hold_full;
      if (!m_active) begin
        if (m_hold_full) begin
          m_cur = m_hold; m_idx = 0; m_active = 1; m_hold_full = 0;
        end
      end else if (shift_en) begin
        if (m_idx < W-1) m_idx++;
        else if (m_hold_full) begin
          m_cur = m_hold; m_idx = 0; m_hold_full = 0;
        end else m_active = 0;
      end
      if (acc) begin
        m_hold = in_data; m_hold_full = 1;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send(input logic [W-1:0] word, input string tag);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = word;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = !m_hold_full;
      cycle(tag);
    end
    chk({tag, ".accepted"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60; k++) begin
      if (!(m_active || m_hold_full)) break;
      cycle(tag);
    end
    chk({tag, ".drained"}, 32'(if_m.busy || if_l.busy), 32'd0);
  endtask

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic chk_stream(input string tag, input int n, input logic [31:0] em, input logic [31:0] el);
    chk({tag, ".m.len"}, 32'(str_m.size()), 32'(n));
    chk({tag, ".m.bits"}, pack(str_m), em);
    chk({tag, ".l.len"}, 32'(str_l.size()), 32'(n));
    chk({tag, ".l.bits"}, pack(str_l), el);
    str_m.delete();
    str_l.delete();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // reset held with random handshakes: nothing is accepted
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      shift_en = 1'($urandom_range(0, 1));
      cycle("rst_hold");
      check_reset_outs("rst_hold");
    end
    rst = 1'b0;
    in_valid = 1'b0;
    shift_en = 1'b1;
    cycle("rst_rel");
    check_reset_outs("rst_rel");

    // single word
    send(4'b1001, "single");
    drain("single");
    chk_stream("single", 4, 32'b1001, 32'b1001);

    // back-to-back with in_valid held high
    send(4'b1001, "b2b");
    send(4'b0110, "b2b");
    send(4'b1111, "b2b");
    drain("b2b");
    chk_stream("b2b", 12, 32'b100101101111, 32'b100101101111);

    // bit order: 1001 then 0011
    send(4'b1001, "order");
    send(4'b0011, "order");
    drain("order");
    chk_stream("order", 8, 32'b10010011, 32'b10011100);

    // stall after the second bit, words offered during the stall
    send(4'b1010, "stall");
    cycle("stall");
    cycle("stall");
    shift_en = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'b0111;
    cycle("stall");
    in_data  = 4'b0010;
    cycle("stall");
    cycle("stall");
    chk("stall.held_off", 32'(if_m.in_ready), 32'd0);
    shift_en = 1'b1;
    send(4'b0010, "stall");
    drain("stall");
    chk_stream("stall", 12, 32'b101001110010, 32'b010111100100);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      shift_en = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end
    in_valid = 1'b0;
    shift_en = 1'b1;
    drain("rand");
    str_m.delete();
    str_l.delete();

    // reset during the second bit of 1100 with 0101 pending
    send(4'b1100, "midrst");
    send(4'b0101, "midrst");
    chk("midrst.pending", 32'(if_m.in_ready), 32'd0);
    chk("midrst.second_bit", 32'(if_m.ser_out), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outs("midrst.async");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = W'($urandom);
    cycle("midrst.hold");
    check_reset_outs("midrst.hold");
    rst = 1'b0;
    in_valid = 1'b0;
    str_m.delete();
    str_l.delete();
    cycle("midrst.rel");
    send(4'b0001, "after_rst");
    drain("after_rst");
    chk_stream("after_rst", 4, 32'b0001, 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
